// File: rtl/cart_loader_if.sv
// Download-stream and SDRAM write-port bundle for the cartridge loader.
// The loader masters the SDRAM write port; the slave view belongs to the HPS/SDRAM side.
interface cart_loader_if;
   logic        ioctl_download;
   logic        ioctl_wr;
   logic [24:0] ioctl_addr;
   logic [7:0]  ioctl_dout;
   logic [7:0]  ioctl_index;
   logic        ioctl_wait;
   logic [23:0] sd_waddr;
   logic [7:0]  sd_din;
   logic        sd_we;
   logic        sd_we_ack;

   modport master (
      input  ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, sd_we_ack,
      output ioctl_wait, sd_waddr, sd_din, sd_we
   );

   modport slave (
      output ioctl_download, ioctl_wr, ioctl_addr, ioctl_dout, ioctl_index, sd_we_ack,
      input  ioctl_wait, sd_waddr, sd_din, sd_we
   );
endinterface

// File: rtl/cart_loader.sv
// Streams an HPS cartridge download into SDRAM one byte at a time over a toggle
// handshake, and derives the ROM address mask / copier-header / Game Gear flags.
module cart_loader #(
   parameter int ACK_TIMEOUT = 1023
) (
   input  logic          clk_sys,
   input  logic          RESET_n,
   cart_loader_if.master bus,
   output logic [21:0]   cart_mask,
   output logic          hdr_skip,
   output logic          gg,
   output logic          busy,
   output logic          load_done,
   output logic          err_timeout,
   output logic          err_overrun
);

   localparam int TO_W = $clog2(ACK_TIMEOUT + 1);
   localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);
   localparam logic [TO_W-1:0] TO_ONE  = TO_W'(1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ARMED = 2'd1,
      ST_XFER  = 2'd2,
      ST_FINAL = 2'd3
   } state_t;

   // Mask contribution of a byte that lies past a 512-byte copier header.
   function automatic logic [21:0] hdr_term(input logic [24:0] addr);
      logic [21:0] term;
      if (addr >= 25'd512) begin
         term = addr[21:0] - 22'd512;
      end else begin
         term = 22'd0;
      end
      return term;
   endfunction

   state_t            state_r, next_state_s;
   logic              dl_prev_r;
   logic              sd_we_r, sd_we_nx_s;
   logic [23:0]       sd_waddr_r, sd_waddr_nx_s;
   logic [7:0]        sd_din_r, sd_din_nx_s;
   logic              ioctl_wait_r, ioctl_wait_nx_s;
   logic [24:0]       cnt_r, cnt_nx_s;
   logic [21:0]       raw_mask_r, raw_mask_nx_s;
   logic [21:0]       hdr_mask_r, hdr_mask_nx_s;
   logic [TO_W-1:0]   to_cnt_r, to_cnt_nx_s;
   logic [21:0]       cart_mask_r, cart_mask_nx_s;
   logic              hdr_skip_r, hdr_skip_nx_s;
   logic              gg_r, gg_nx_s;
   logic              busy_r, busy_nx_s;
   logic              load_done_r, load_done_nx_s;
   logic              err_timeout_r, err_timeout_nx_s;
   logic              err_overrun_r, err_overrun_nx_s;

   logic              dl_rise_s;
   logic              pending_s;
   logic              to_hit_s;
   logic              unused_idx_s;

   assign dl_rise_s    = bus.ioctl_download & ~dl_prev_r;
   assign pending_s    = (sd_we_r != bus.sd_we_ack);
   assign to_hit_s     = (to_cnt_r == TO_LAST);
   assign unused_idx_s = ^bus.ioctl_index[7:5];

   // State register.
   always_ff @(posedge clk_sys or negedge RESET_n) begin
      if (!RESET_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; a download rising edge restarts from any state.
   always_comb begin
      next_state_s = state_r;
      if (dl_rise_s) begin
         next_state_s = ST_ARMED;
      end else begin
         case (state_r)
            ST_IDLE:  next_state_s = ST_IDLE;
            ST_ARMED: begin
               if (!bus.ioctl_download) begin
                  next_state_s = ST_FINAL;
               end else if (bus.ioctl_wr) begin
                  next_state_s = ST_XFER;
               end else begin
                  next_state_s = ST_ARMED;
               end
            end
            ST_XFER: begin
               if (!pending_s || to_hit_s) begin
                  next_state_s = bus.ioctl_download ? ST_ARMED : ST_FINAL;
               end else begin
                  next_state_s = ST_XFER;
               end
            end
            ST_FINAL: next_state_s = ST_IDLE;
            default:  next_state_s = ST_IDLE;
         endcase
      end
   end

   // Output/datapath next values, registered below.
   always_comb begin
      sd_we_nx_s       = sd_we_r;
      sd_waddr_nx_s    = sd_waddr_r;
      sd_din_nx_s      = sd_din_r;
      ioctl_wait_nx_s  = ioctl_wait_r;
      cnt_nx_s         = cnt_r;
      raw_mask_nx_s    = raw_mask_r;
      hdr_mask_nx_s    = hdr_mask_r;
      to_cnt_nx_s      = to_cnt_r;
      cart_mask_nx_s   = cart_mask_r;
      hdr_skip_nx_s    = hdr_skip_r;
      gg_nx_s          = gg_r;
      load_done_nx_s   = 1'b0;
      err_timeout_nx_s = err_timeout_r;
      err_overrun_nx_s = err_overrun_r;
      busy_nx_s        = (next_state_s != ST_IDLE);

      if (dl_rise_s) begin
         sd_waddr_nx_s    = 24'd0;
         ioctl_wait_nx_s  = 1'b0;
         cnt_nx_s         = 25'd0;
         raw_mask_nx_s    = 22'd0;
         hdr_mask_nx_s    = 22'd0;
         to_cnt_nx_s      = {TO_W{1'b0}};
         err_timeout_nx_s = 1'b0;
         err_overrun_nx_s = 1'b0;
         gg_nx_s          = (bus.ioctl_index[4:0] == 5'd2);
      end else begin
         case (state_r)
            ST_IDLE: begin
               ioctl_wait_nx_s = 1'b0;
            end
            ST_ARMED: begin
               if (bus.ioctl_download && bus.ioctl_wr) begin
                  sd_din_nx_s     = bus.ioctl_dout;
                  sd_we_nx_s      = ~sd_we_r;
                  ioctl_wait_nx_s = 1'b1;
                  to_cnt_nx_s     = {TO_W{1'b0}};
                  raw_mask_nx_s   = raw_mask_r | bus.ioctl_addr[21:0];
                  hdr_mask_nx_s   = hdr_mask_r | hdr_term(bus.ioctl_addr);
               end else begin
                  ioctl_wait_nx_s = 1'b0;
               end
            end
            ST_XFER: begin
               if (bus.ioctl_wr) begin
                  err_overrun_nx_s = 1'b1;
               end else begin
                  err_overrun_nx_s = err_overrun_r;
               end
               if (!pending_s || to_hit_s) begin
                  ioctl_wait_nx_s = 1'b0;
                  sd_waddr_nx_s   = sd_waddr_r + 24'd1;
                  cnt_nx_s        = cnt_r + 25'd1;
                  // A timed-out request is retired by re-aligning the toggle pair.
                  if (pending_s) begin
                     err_timeout_nx_s = 1'b1;
                     sd_we_nx_s       = bus.sd_we_ack;
                  end else begin
                     err_timeout_nx_s = err_timeout_r;
                  end
               end else begin
                  to_cnt_nx_s = to_cnt_r + TO_ONE;
               end
            end
            ST_FINAL: begin
               hdr_skip_nx_s  = (cnt_r[9:0] == 10'd512);
               load_done_nx_s = 1'b1;
               if (cnt_r[9:0] == 10'd512) begin
                  cart_mask_nx_s = hdr_mask_r;
               end else begin
                  cart_mask_nx_s = raw_mask_r;
               end
            end
            default: begin
               ioctl_wait_nx_s = 1'b0;
            end
         endcase
      end
   end

   // Datapath and output registers.
   always_ff @(posedge clk_sys or negedge RESET_n) begin
      if (!RESET_n) begin
         dl_prev_r     <= 1'b0;
         sd_we_r       <= 1'b0;
         sd_waddr_r    <= 24'd0;
         sd_din_r      <= 8'd0;
         ioctl_wait_r  <= 1'b0;
         cnt_r         <= 25'd0;
         raw_mask_r    <= 22'd0;
         hdr_mask_r    <= 22'd0;
         to_cnt_r      <= {TO_W{1'b0}};
         cart_mask_r   <= 22'd0;
         hdr_skip_r    <= 1'b0;
         gg_r          <= 1'b0;
         busy_r        <= 1'b0;
         load_done_r   <= 1'b0;
         err_timeout_r <= 1'b0;
         err_overrun_r <= 1'b0;
      end else begin
         dl_prev_r     <= bus.ioctl_download;
         sd_we_r       <= sd_we_nx_s;
         sd_waddr_r    <= sd_waddr_nx_s;
         sd_din_r      <= sd_din_nx_s;
         ioctl_wait_r  <= ioctl_wait_nx_s;
         cnt_r         <= cnt_nx_s;
         raw_mask_r    <= raw_mask_nx_s;
         hdr_mask_r    <= hdr_mask_nx_s;
         to_cnt_r      <= to_cnt_nx_s;
         cart_mask_r   <= cart_mask_nx_s;
         hdr_skip_r    <= hdr_skip_nx_s;
         gg_r          <= gg_nx_s;
         busy_r        <= busy_nx_s;
         load_done_r   <= load_done_nx_s;
         err_timeout_r <= err_timeout_nx_s;
         err_overrun_r <= err_overrun_nx_s;
      end
   end

   assign bus.sd_we      = sd_we_r;
   assign bus.sd_waddr   = sd_waddr_r;
   assign bus.sd_din     = sd_din_r;
   assign bus.ioctl_wait = ioctl_wait_r;
   assign cart_mask      = cart_mask_r;
   assign hdr_skip       = hdr_skip_r;
   assign gg             = gg_r;
   assign busy           = busy_r;
   assign load_done      = load_done_r;
   assign err_timeout    = err_timeout_r;
   assign err_overrun    = err_overrun_r;

endmodule

// File: tb/tb_cart_loader.sv
// Self-checking bench for cart_loader: the bench plays HPS and SDRAM and keeps a
// byte-level reference model of the address masks, byte count and final flags.
module tb_cart_loader;
   logic        clk_sys = 1'b0;
   logic        RESET_n;
   logic [21:0] cart_mask;
   logic        hdr_skip, gg, busy, load_done, err_timeout, err_overrun;

   cart_loader_if bus ();

   cart_loader #(.ACK_TIMEOUT(15)) dut (
      .clk_sys     (clk_sys),
      .RESET_n     (RESET_n),
      .bus         (bus),
      .cart_mask   (cart_mask),
      .hdr_skip    (hdr_skip),
      .gg          (gg),
      .busy        (busy),
      .load_done   (load_done),
      .err_timeout (err_timeout),
      .err_overrun (err_overrun)
   );

   always #5 clk_sys = ~clk_sys;

   int chk_cnt  = 0;
   int pass_cnt = 0;

   int   we_changes  = 0;
   int   done_pulses = 0;
   logic we_prev     = 1'b0;

   // Count every sd_we transition and every load_done cycle.
   always @(negedge clk_sys) begin
      if (bus.sd_we !== we_prev) we_changes <= we_changes + 1;
      we_prev <= bus.sd_we;
      if (load_done === 1'b1) done_pulses <= done_pulses + 1;
   end

   // Reference model state
   logic [23:0] m_addr;
   logic [24:0] m_cnt;
   logic [21:0] m_raw, m_hdr;
   logic        m_gg;

   task automatic tick();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic model_clear(input logic [7:0] idx);
      m_addr = 24'd0;
      m_cnt  = 25'd0;
      m_raw  = 22'd0;
      m_hdr  = 22'd0;
      m_gg   = ((idx % 32) == 2);
   endtask

   task automatic model_accept(input logic [24:0] a);
      m_raw = m_raw | a[21:0];
      if (a >= 512) m_hdr = m_hdr | 22'(a - 512);
      m_cnt  = m_cnt + 25'd1;
      m_addr = m_addr + 24'd1;
   endtask

   task automatic start_dl(input logic [7:0] idx);
      bus.ioctl_download = 1'b0;
      tick();
      bus.ioctl_index    = idx;
      bus.ioctl_download = 1'b1;
      tick();
      model_clear(idx);
      chk_cnt++; if (busy !== 1'b1) $display("FAIL start_busy: got %b exp 1", busy); else pass_cnt++;
      chk_cnt++; if (bus.sd_waddr !== 24'd0) $display("FAIL start_waddr: got %h exp 0", bus.sd_waddr); else pass_cnt++;
      chk_cnt++; if ({err_timeout, err_overrun} !== 2'b00) $display("FAIL start_errs: got %b exp 00", {err_timeout, err_overrun}); else pass_cnt++;
      chk_cnt++; if (gg !== m_gg) $display("FAIL start_gg: got %b exp %b", gg, m_gg); else pass_cnt++;
   endtask

   task automatic send_byte(input logic [24:0] a, input int lat);
      logic [7:0] d;
      logic       we0;
      d   = 8'($urandom);
      we0 = bus.sd_we;
      bus.ioctl_addr = a;
      bus.ioctl_dout = d;
      bus.ioctl_wr   = 1'b1;
      tick();
      bus.ioctl_wr   = 1'b0;
      chk_cnt++; if (bus.sd_din !== d) $display("FAIL byte_din: got %h exp %h", bus.sd_din, d); else pass_cnt++;
      chk_cnt++; if (bus.sd_we !== ~we0) $display("FAIL byte_toggle: got %b exp %b", bus.sd_we, ~we0); else pass_cnt++;
      chk_cnt++; if (bus.ioctl_wait !== 1'b1) $display("FAIL byte_wait_on: got %b exp 1", bus.ioctl_wait); else pass_cnt++;
      for (int i = 0; i < lat; i++) begin
         tick();
         chk_cnt++; if (bus.ioctl_wait !== 1'b1) $display("FAIL byte_wait_hold: got %b exp 1", bus.ioctl_wait); else pass_cnt++;
      end
      bus.sd_we_ack = bus.sd_we;
      tick();
      model_accept(a);
      chk_cnt++; if (bus.ioctl_wait !== 1'b0) $display("FAIL byte_wait_off: got %b exp 0", bus.ioctl_wait); else pass_cnt++;
      chk_cnt++; if (bus.sd_waddr !== m_addr) $display("FAIL byte_waddr: got %h exp %h", bus.sd_waddr, m_addr); else pass_cnt++;
   endtask

   task automatic finish_dl();
      logic        skip;
      logic [21:0] mask;
      skip = ((m_cnt % 1024) == 512);
      mask = skip ? m_hdr : m_raw;
      bus.ioctl_download = 1'b0;
      tick();
      chk_cnt++; if ({busy, load_done} !== 2'b10) $display("FAIL fin_final: got busy/done %b exp 10", {busy, load_done}); else pass_cnt++;
      tick();
      chk_cnt++; if ({busy, load_done} !== 2'b01) $display("FAIL fin_done: got busy/done %b exp 01", {busy, load_done}); else pass_cnt++;
      chk_cnt++; if (hdr_skip !== skip) $display("FAIL fin_hdr_skip: got %b exp %b", hdr_skip, skip); else pass_cnt++;
      chk_cnt++; if (cart_mask !== mask) $display("FAIL fin_cart_mask: got %h exp %h", cart_mask, mask); else pass_cnt++;
      chk_cnt++; if (gg !== m_gg) $display("FAIL fin_gg: got %b exp %b", gg, m_gg); else pass_cnt++;
      tick();
      chk_cnt++; if (load_done !== 1'b0) $display("FAIL fin_pulse_end: got %b exp 0", load_done); else pass_cnt++;
      chk_cnt++; if (cart_mask !== mask) $display("FAIL fin_mask_hold: got %h exp %h", cart_mask, mask); else pass_cnt++;
   endtask

   task automatic test_reset();
      logic [61:0] snap;
      RESET_n            = 1'b0;
      bus.ioctl_download = 1'b0;
      bus.ioctl_wr       = 1'b0;
      bus.ioctl_addr     = 25'd0;
      bus.ioctl_dout     = 8'd0;
      bus.ioctl_index    = 8'd0;
      bus.sd_we_ack      = 1'b0;
      #3;
      snap = {bus.ioctl_wait, bus.sd_we, bus.sd_waddr, bus.sd_din, cart_mask,
              hdr_skip, gg, busy, load_done, err_timeout, err_overrun};
      chk_cnt++; if (snap !== 62'd0) $display("FAIL reset_state: got %h exp 0", snap); else pass_cnt++;
      tick();
      tick();
      RESET_n = 1'b1;
      tick();
   endtask

   task automatic test_basic();
      int c0, d0;
      c0 = we_changes;
      d0 = done_pulses;
      start_dl(8'd1);
      for (int i = 0; i < 4; i++) send_byte(25'(i), 3);
      finish_dl();
      chk_cnt++; if (we_changes - c0 != 4) $display("FAIL basic_toggles: got %0d exp 4", we_changes - c0); else pass_cnt++;
      chk_cnt++; if (done_pulses - d0 != 1) $display("FAIL basic_done: got %0d exp 1", done_pulses - d0); else pass_cnt++;
      chk_cnt++; if (bus.sd_waddr !== 24'd4) $display("FAIL basic_waddr: got %h exp 4", bus.sd_waddr); else pass_cnt++;
      chk_cnt++; if ({cart_mask, hdr_skip, gg} !== {22'h3, 1'b0, 1'b0}) $display("FAIL basic_flags: got %h/%b/%b exp 3/0/0", cart_mask, hdr_skip, gg); else pass_cnt++;
   endtask

   task automatic test_random();
      logic [24:0] a;
      for (int k = 0; k < 6; k++) begin
         start_dl(8'($urandom));
         for (int n = $urandom_range(1, 24); n > 0; n--) begin
            if ($urandom_range(0, 1) == 1) a = 25'($urandom_range(0, 1023));
            else a = 25'($urandom);
            send_byte(a, $urandom_range(0, 4));
         end
         finish_dl();
      end
   endtask

   task automatic test_header();
      start_dl(8'h42);
      for (int i = 0; i < 2560; i++) send_byte(25'(i), 0);
      finish_dl();
      chk_cnt++; if ({cart_mask, hdr_skip, gg} !== {22'h7FF, 1'b1, 1'b1}) $display("FAIL header_flags: got %h/%b/%b exp 7ff/1/1", cart_mask, hdr_skip, gg); else pass_cnt++;
   endtask

   task automatic test_timeout();
      int c0;
      start_dl(8'd3);
      c0 = we_changes;
      send_byte(25'd0, 1);
      send_byte(25'd1, 2);
      bus.ioctl_addr = 25'd2;
      bus.ioctl_dout = 8'h77;
      bus.ioctl_wr   = 1'b1;
      tick();
      bus.ioctl_wr   = 1'b0;
      for (int k = 1; k < 15; k++) begin
         tick();
         chk_cnt++; if ({err_timeout, bus.ioctl_wait} !== 2'b01) $display("FAIL to_wait cyc%0d: got err/wait %b exp 01", k, {err_timeout, bus.ioctl_wait}); else pass_cnt++;
      end
      tick();
      model_accept(25'd2);
      chk_cnt++; if ({err_timeout, bus.ioctl_wait} !== 2'b10) $display("FAIL to_fire: got err/wait %b exp 10", {err_timeout, bus.ioctl_wait}); else pass_cnt++;
      chk_cnt++; if (bus.sd_we !== bus.sd_we_ack) $display("FAIL to_realign: got we %b exp %b", bus.sd_we, bus.sd_we_ack); else pass_cnt++;
      chk_cnt++; if (bus.sd_waddr !== 24'd3) $display("FAIL to_waddr: got %h exp 3", bus.sd_waddr); else pass_cnt++;
      send_byte(25'd3, 2);
      chk_cnt++; if (err_timeout !== 1'b1) $display("FAIL to_sticky: got %b exp 1", err_timeout); else pass_cnt++;
      finish_dl();
      // four requests plus the forced re-alignment after the timeout
      chk_cnt++; if (we_changes - c0 != 5) $display("FAIL to_changes: got %0d exp 5", we_changes - c0); else pass_cnt++;
   endtask

   task automatic test_overrun();
      int c0;
      start_dl(8'd0);
      c0 = we_changes;
      bus.ioctl_addr = 25'd0;
      bus.ioctl_dout = 8'h5A;
      bus.ioctl_wr   = 1'b1;
      tick();
      bus.ioctl_addr = 25'd1;
      bus.ioctl_dout = 8'hA5;
      tick();
      bus.ioctl_wr   = 1'b0;
      chk_cnt++; if (err_overrun !== 1'b1) $display("FAIL ovr_flag: got %b exp 1", err_overrun); else pass_cnt++;
      chk_cnt++; if (bus.sd_din !== 8'h5A) $display("FAIL ovr_din: got %h exp 5a", bus.sd_din); else pass_cnt++;
      chk_cnt++; if ({bus.sd_waddr, bus.ioctl_wait} !== {24'd0, 1'b1}) $display("FAIL ovr_hold: got %h/%b exp 0/1", bus.sd_waddr, bus.ioctl_wait); else pass_cnt++;
      bus.sd_we_ack = bus.sd_we;
      tick();
      model_accept(25'd0);
      chk_cnt++; if (bus.sd_waddr !== 24'd1) $display("FAIL ovr_waddr: got %h exp 1", bus.sd_waddr); else pass_cnt++;
      finish_dl();
      chk_cnt++; if (err_overrun !== 1'b1) $display("FAIL ovr_sticky: got %b exp 1", err_overrun); else pass_cnt++;
      chk_cnt++; if (we_changes - c0 != 1) $display("FAIL ovr_toggles: got %0d exp 1", we_changes - c0); else pass_cnt++;
   endtask

   task automatic test_reset_mid();
      logic [61:0] snap;
      start_dl(8'd2);
      for (int i = 0; i < 100; i++) send_byte(25'(i), 0);
      bus.ioctl_addr = 25'd100;
      bus.ioctl_wr   = 1'b1;
      tick();
      bus.ioctl_wr   = 1'b0;
      chk_cnt++; if (bus.ioctl_wait !== 1'b1) $display("FAIL rstmid_pending: got %b exp 1", bus.ioctl_wait); else pass_cnt++;
      RESET_n = 1'b0;
      #1;
      snap = {bus.ioctl_wait, bus.sd_we, bus.sd_waddr, bus.sd_din, cart_mask,
              hdr_skip, gg, busy, load_done, err_timeout, err_overrun};
      chk_cnt++; if (snap !== 62'd0) $display("FAIL rstmid_state: got %h exp 0", snap); else pass_cnt++;
      bus.ioctl_download = 1'b0;
      bus.sd_we_ack      = 1'b0;
      tick();
      #2;
      RESET_n = 1'b1;
      tick();
      start_dl(8'd1);
      send_byte(25'd0, 1);
      finish_dl();
   endtask

   task automatic test_fall_pending();
      start_dl(8'd5);
      send_byte(25'd0, 1);
      bus.ioctl_addr = 25'd1;
      bus.ioctl_wr   = 1'b1;
      tick();
      bus.ioctl_wr       = 1'b0;
      bus.ioctl_download = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_cnt++; if ({busy, load_done, bus.ioctl_wait} !== 3'b101) $display("FAIL fall_hold: got busy/done/wait %b exp 101", {busy, load_done, bus.ioctl_wait}); else pass_cnt++;
      end
      bus.sd_we_ack = bus.sd_we;
      tick();
      model_accept(25'd1);
      chk_cnt++; if ({busy, load_done, bus.ioctl_wait} !== 3'b100) $display("FAIL fall_complete: got busy/done/wait %b exp 100", {busy, load_done, bus.ioctl_wait}); else pass_cnt++;
      chk_cnt++; if (bus.sd_waddr !== 24'd2) $display("FAIL fall_waddr: got %h exp 2", bus.sd_waddr); else pass_cnt++;
      tick();
      chk_cnt++; if ({busy, load_done} !== 2'b01) $display("FAIL fall_done: got busy/done %b exp 01", {busy, load_done}); else pass_cnt++;
      chk_cnt++; if ({cart_mask, hdr_skip} !== {22'h1, 1'b0}) $display("FAIL fall_mask: got %h/%b exp 1/0", cart_mask, hdr_skip); else pass_cnt++;
      tick();
      chk_cnt++; if (load_done !== 1'b0) $display("FAIL fall_pulse_end: got %b exp 0", load_done); else pass_cnt++;
   endtask

   task automatic test_ignore_idle();
      logic        we0;
      logic [23:0] a0;
      we0 = bus.sd_we;
      a0  = bus.sd_waddr;
      bus.ioctl_wr = 1'b1;
      tick();
      bus.ioctl_wr = 1'b0;
      tick();
      chk_cnt++; if ({bus.sd_we, bus.sd_waddr} !== {we0, a0}) $display("FAIL idle_wr: got %b/%h exp %b/%h", bus.sd_we, bus.sd_waddr, we0, a0); else pass_cnt++;
      chk_cnt++; if ({busy, bus.ioctl_wait} !== 2'b00) $display("FAIL idle_busy: got busy/wait %b exp 00", {busy, bus.ioctl_wait}); else pass_cnt++;
   endtask

   task automatic test_restart();
      logic we_now;
      start_dl(8'd1);
      send_byte(25'd0, 0);
      send_byte(25'd1, 0);
      bus.ioctl_addr = 25'd2;
      bus.ioctl_wr   = 1'b1;
      tick();
      bus.ioctl_wr   = 1'b0;
      we_now = bus.sd_we;
      bus.ioctl_download = 1'b0;
      tick();
      bus.ioctl_index    = 8'd2;
      bus.ioctl_download = 1'b1;
      tick();
      model_clear(8'd2);
      chk_cnt++; if ({bus.sd_waddr, bus.ioctl_wait, busy} !== {24'd0, 1'b0, 1'b1}) $display("FAIL rst_dl_state: got %h/%b/%b exp 0/0/1", bus.sd_waddr, bus.ioctl_wait, busy); else pass_cnt++;
      chk_cnt++; if (bus.sd_we !== we_now) $display("FAIL rst_dl_we: got %b exp %b", bus.sd_we, we_now); else pass_cnt++;
      chk_cnt++; if (gg !== 1'b1) $display("FAIL rst_dl_gg: got %b exp 1", gg); else pass_cnt++;
      bus.sd_we_ack = bus.sd_we;
      send_byte(25'd7, 1);
      finish_dl();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_random();
      test_header();
      test_timeout();
      test_overrun();
      test_reset_mid();
      test_fall_pending();
      test_ignore_idle();
      test_restart();
      $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
      $finish;
   end
endmodule

// File: doc/cart_loader.md
CART_LOADER -- requirements
Module: cart_loader

Interface
REQ-001 SHALL have parameter ACK_TIMEOUT, default 1023, meaning max clk_sys cycles from write request to sd_we_ack match before error.
REQ-002 SHALL have port clk_sys  in  1  system clock; all state on rising edge.
REQ-003 SHALL have port RESET_n  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports ioctl_download in 1, ioctl_wr in 1 (1-cycle strobe), ioctl_addr in 25, ioctl_dout in 8, ioctl_index in 8: HPS download stream.
REQ-005 SHALL have port ioctl_wait  out  1  stall to HPS while a byte is in flight.
REQ-006 SHALL have ports sd_waddr out 24, sd_din out 8, sd_we out 1 (toggle request), sd_we_ack in 1 (toggle acknowledge): SDRAM write port.
REQ-007 SHALL have ports cart_mask out 22 (ROM address mask), hdr_skip out 1 (512-byte copier header present), gg out 1 (Game Gear image).
REQ-008 SHALL have ports busy out 1, load_done out 1 (1-cycle pulse), err_timeout out 1, err_overrun out 1 (sticky).

Function
REQ-009 SHALL implement FSM states IDLE, ARMED, XFER, FINAL.
REQ-010 IDLE->ARMED on ioctl_download 0->1: sd_waddr=0, byte count=0, raw/hdr masks=0, error flags cleared, gg latched = (ioctl_index[4:0]==2).
REQ-011 ARMED: on ioctl_wr, latch ioctl_dout into sd_din, invert sd_we, assert ioctl_wait next cycle, enter XFER.
REQ-012 Request pending SHALL be defined as sd_we != sd_we_ack; exactly one toggle per accepted byte.
REQ-013 XFER: when sd_we == sd_we_ack, next cycle deassert ioctl_wait, sd_waddr += 1, byte count += 1, return to ARMED.
REQ-014 Per accepted byte: raw mask |= ioctl_addr[21:0]; if ioctl_addr >= 512, hdr mask |= (ioctl_addr[21:0] - 512), 22-bit wrap arithmetic.
REQ-015 ioctl_download 1->0 in ARMED -> FINAL; in XFER the pending byte SHALL complete first, then FINAL.
REQ-016 FINAL (1 cycle): hdr_skip = (byte count[9:0]==512); cart_mask = hdr_skip ? hdr mask : raw mask; load_done pulse; -> IDLE.
REQ-017 cart_mask, hdr_skip, gg SHALL update only in FINAL (or at REQ-010 for gg) and hold otherwise.
REQ-018 ioctl_wr while in XFER SHALL be dropped (no toggle, no address change) and set err_overrun.
REQ-019 Timeout counter SHALL clear on entering XFER and count each XFER cycle; reaching ACK_TIMEOUT sets err_timeout, forces sd_we = sd_we_ack, deasserts ioctl_wait, advances sd_waddr, returns to ARMED.
REQ-020 ioctl_download rising edge in any state other than IDLE SHALL restart per REQ-010 (pending toggle abandoned, sd_we preserved).
REQ-021 busy SHALL be 1 in ARMED, XFER, FINAL; 0 in IDLE.
REQ-022 sd_waddr at 24-bit all-ones SHALL wrap to 0; byte count SHALL be 25 bits.
REQ-023 ioctl_wr in IDLE SHALL be ignored.

Reset
REQ-024 RESET_n low SHALL asynchronously force: state IDLE, ioctl_wait 0, sd_we 0, sd_waddr 0, sd_din 0, cart_mask 0, hdr_skip 0, gg 0, busy 0, load_done 0, both error flags 0, internal counters/masks 0.
REQ-025 Reset mid-transfer SHALL abandon the byte; SDRAM side is reset concurrently, so no ack resynchronisation is required.
REQ-026 After RESET_n release, first ioctl_download rise SHALL behave per REQ-010.

Verification
REQ-027 4-byte download, index 1, ack 3 cycles after each toggle -> 4 sd_we toggles, sd_waddr 0..3 then 4, cart_mask=0x3, hdr_skip 0, gg 0, one load_done.
REQ-028 32768+512 byte download, index 2 -> hdr_skip 1, cart_mask=0x7FFF, gg 1, ioctl_wait high exactly during each pending window.
REQ-029 ACK_TIMEOUT=15, ack never returns on byte 2 -> err_timeout set on cycle 15 of XFER, sd_waddr advances, remaining bytes complete normally.
REQ-030 Extra ioctl_wr during XFER -> err_overrun 1, toggle count unchanged, sd_din holds first byte.
REQ-031 RESET_n low 1 cycle during XFER of byte 100 -> all outputs zero same cycle; new download restarts at sd_waddr 0.
REQ-032 ioctl_download falls while byte pending -> FINAL only after ack; load_done one cycle after ack cycle plus completion.
